pkt_fifo_sf: RTL
================

// Module: pkt_fifo_sf
// PURPOSE
//  Store-and-forward AXI-Stream packet FIFO; successor to the single-width queue, generalised in width and depth.
//  A packet is released downstream only after its tlast beat is written.
//  On overflow or on drop_incmpt_pkt the partial packet is rolled back and the rest of it is sunk.
//  m_axis honours tready on every beat (no replay/rewind); sits between MAC RX and the flow-speed parser.
// PARAMETERS
//  C_DATA_WIDTH      256  tdata width (bits)
//  C_MTY_WIDTH       5    tuser_mty width (empty-byte count of last beat)
//  C_MAX_DEPTH_BITS  9    log2 of RAM depth; usable capacity = 2**C_MAX_DEPTH_BITS beats
//  C_PKT_CNT_BITS    8    width of packet counters
// PORTS
//  aclk              in   1    clock
//  areset            in   1    reset: synchronous to aclk, active-high
//  s_axis_tvalid     in   1    input beat valid
//  s_axis_tdata      in   DW   input data
//  s_axis_tlast      in   1    last beat of packet
//  s_axis_tuser_mty  in   MW   empty bytes; meaningful on tlast only
//  s_axis_tready     out  1    input ready
//  drop_incmpt_pkt   in   1    discard the packet currently being written
//  m_axis_tvalid     out  1    output beat valid
//  m_axis_tdata      out  DW   output data
//  m_axis_tlast      out  1    output last
//  m_axis_tuser_mty  out  MW   output mty
//  m_axis_tready     in   1    downstream ready
//  pkt_cnt           out  PCW  committed packets held; saturates, never wraps
// BEHAVIOUR
//  Reset: all pointers 0; m_axis_tvalid/tdata/tlast/tuser_mty=0; s_axis_tready=0 during reset, 1 on the first cycle after; pkt_cnt=0; write FSM=WR_IDLE.
//   Reset mid-packet discards everything, including committed packets.
//  Pointers: wr_p (speculative), cm_p (commit), rd_p; each C_MAX_DEPTH_BITS+1 wide, wrap modulo 2**(C_MAX_DEPTH_BITS+1).
//   full  = (wr_p - rd_p) == 2**C_MAX_DEPTH_BITS
//   avail = (cm_p != rd_p)
//  Write FSM:
//   WR_IDLE/WR_PKT: a beat is accepted when s_axis_tvalid && s_axis_tready.
//    Not full: beat is written to RAM[wr_p] and wr_p++.
//    Accepted beat with tlast: cm_p <= wr_p+1 on the same edge; pkt_cnt++; -> WR_IDLE.
//    Accepted beat while full: beat is not written; wr_p <= cm_p; -> WR_DROP (tlast on it -> WR_IDLE instead).
//    drop_incmpt_pkt=1: wr_p <= cm_p; -> WR_DROP. If a tlast beat is accepted in the same cycle, drop wins: nothing is committed -> WR_IDLE.
//   WR_DROP: s_axis_tready=1; beats are consumed and discarded until tlast -> WR_IDLE.
//   s_axis_tready=1 in every state after reset; overflow is handled by dropping, never by back-pressure.
//   A packet longer than 2**C_MAX_DEPTH_BITS beats is always dropped.
//  Read side:
//   1-cycle-latency RAM feeds a 2-entry output skid buffer; full throughput, 1 beat/cycle when tready=1.
//   Reads are issued only while avail and the skid has room.
//   m_axis_* is held stable while m_axis_tvalid && !m_axis_tready.
//   Latency: if the FIFO is empty and tready=1, the first beat appears on m_axis exactly 3 cycles after the edge that accepted its tlast.
//   pkt_cnt-- on a handshaked tlast output beat. Simultaneous ++/-- leaves it unchanged.
//   rd_p never passes cm_p: uncommitted data is never visible downstream.
//  Simultaneous write and read at the full boundary: full is evaluated on the pre-edge pointers, so the incoming beat is dropped.
// CONFIGURATION
//  PKT_FIFO_DROP_STATS_EN defined: adds output drop_cnt [31:0]; +1 per dropped packet (overflow or drop_incmpt_pkt); saturating; reset 0.
//  Not defined: port and counter are absent; behaviour is otherwise identical.
// STRUCTURE
//  pkt_fifo_pkg: FSM state encoding (WR_IDLE, WR_PKT, WR_DROP), beat-packing width localparam, pointer helpers.
//  One sub-module, sdp_ram: simple dual-port RAM, width DW+MW+1, depth 2**C_MAX_DEPTH_BITS, 1-cycle read latency, no output reg.
//  Write FSM, pointer logic and skid buffer stay in pkt_fifo_sf.
// TESTING (C_MAX_DEPTH_BITS=4, i.e. 16 beats, unless noted)
//  1 Single 4-beat packet, tready=1 -> m_axis carries the same 4 beats 3 cycles after tlast, mty intact; pkt_cnt goes 0->1->0.
//  2 Three back-to-back 5-beat packets, tready toggling 1010... -> order preserved; no duplicated or lost beats; tdata stable while stalled.
//  3 20-beat packet into empty FIFO -> nothing is output; s_axis_tready stays 1; pkt_cnt=0; drop_cnt=1 if PKT_FIFO_DROP_STATS_EN.
//  4 10-beat packet committed, tready=0, then an 8-beat packet -> the 2nd packet overflows and is dropped;
//    after tready=1 only the 10-beat packet emerges.
//  5 drop_incmpt_pkt pulsed on beat 3 of a 6-beat packet, then a 2-beat packet -> only the 2-beat packet is output.
//  6 areset asserted for 1 cycle mid-output of a packet -> m_axis_tvalid=0 the next cycle; pkt_cnt=0; a fresh packet then passes normally.

Source files
------------

// File: rtl/pkt_fifo_sf_pkg.sv
// Shared types and helpers for the store-and-forward packet FIFO.
package pkt_fifo_sf_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_PKT  = 2'd1,
    WR_DROP = 2'd2
  } wr_state_e;

  // Control bits packed next to tdata/mty in each RAM word (tlast).
  localparam int BEAT_CTRL_W = 1;

  function automatic int beat_w(input int dw, input int mw);
    return dw + mw + BEAT_CTRL_W;
  endfunction

  // Pointers are aw+1 bits wide; full when they differ by exactly 2**aw.
  function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd, input int aw);
    logic [31:0] used;
    used = (wr - rd) & ((32'd1 << (aw + 1)) - 32'd1);
    return used == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/pkt_fifo_sf_if.sv
// AXI-Stream beat bundle with tuser_mty; master drives the beat, slave drives tready.
interface pkt_fifo_sf_if #(
  parameter int DW = 256,
  parameter int MW = 5
) ();
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;
  logic [MW-1:0] tuser_mty;
  logic          tready;

  modport master (output tvalid, tdata, tlast, tuser_mty, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser_mty, output tready);
endinterface

// File: rtl/pkt_fifo_sf_sdp_ram.sv
// Simple dual-port RAM, one write and one read port, 1-cycle read latency.
module sdp_ram #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end
endmodule

// File: rtl/pkt_fifo_sf.sv
// Store-and-forward AXI-Stream packet FIFO with rollback of partial/overflowing packets.
// Optional PKT_FIFO_DROP_STATS_EN adds a saturating drop_cnt output.
module pkt_fifo_sf
  import pkt_fifo_sf_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 256,
  parameter int C_MTY_WIDTH      = 5,
  parameter int C_MAX_DEPTH_BITS = 9,
  parameter int C_PKT_CNT_BITS   = 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  pkt_fifo_sf_if.slave              s_axis,
  input  logic                      drop_incmpt_pkt,
  pkt_fifo_sf_if.master             m_axis,
  output logic [C_PKT_CNT_BITS-1:0] pkt_cnt
`ifdef PKT_FIFO_DROP_STATS_EN
  , output logic [31:0]             drop_cnt
`endif
);
  localparam int DW = C_DATA_WIDTH;
  localparam int MW = C_MTY_WIDTH;
  localparam int AW = C_MAX_DEPTH_BITS;
  localparam int PW = AW + 1;
  localparam int BW = beat_w(DW, MW);

  wr_state_e           state_q;
  logic                s_rdy_q;
  logic [PW-1:0]       wr_p_q, cm_p_q, cm_vis_q, ra_p_q, rd_p_q;
  logic [C_PKT_CNT_BITS-1:0] pkt_cnt_q;
  logic                rd_vld_q;
  logic [1:0]          sk_cnt_q;
  logic [BW-1:0]       sk0_q, sk1_q, ram_rdata;

  logic acc, full, drop_ev, we, commit, pop, last_out, issue;
  logic [2:0] occ;

  assign acc     = s_axis.tvalid && s_rdy_q;
  assign full    = ptr_full(32'(wr_p_q), 32'(rd_p_q), AW);
  assign drop_ev = (state_q != WR_DROP) && (drop_incmpt_pkt || (acc && full));
  assign we      = acc && !full && !drop_incmpt_pkt && (state_q != WR_DROP);
  assign commit  = we && s_axis.tlast;
  assign s_axis.tready = s_rdy_q;

  sdp_ram #(.W(BW), .AW(AW)) u_ram (
    .clk     (aclk),
    .we_i    (we),
    .waddr_i (wr_p_q[AW-1:0]),
    .wdata_i ({s_axis.tlast, s_axis.tuser_mty, s_axis.tdata}),
    .re_i    (issue),
    .raddr_i (ra_p_q[AW-1:0]),
    .rdata_o (ram_rdata)
  );

  // Write FSM: wr_p runs ahead speculatively, cm_p only moves on a clean tlast.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= WR_IDLE;
      s_rdy_q <= 1'b0;
      wr_p_q  <= '0;
      cm_p_q  <= '0;
    end else begin
      s_rdy_q <= 1'b1;
      case (state_q)
        WR_IDLE, WR_PKT: begin
          if (drop_ev) begin
            wr_p_q  <= cm_p_q;
            state_q <= (acc && s_axis.tlast) ? WR_IDLE : WR_DROP;
          end else if (we) begin
            wr_p_q <= wr_p_q + 1'b1;
            if (s_axis.tlast) begin
              cm_p_q  <= wr_p_q + 1'b1;
              state_q <= WR_IDLE;
            end else begin
              state_q <= WR_PKT;
            end
          end
        end
        WR_DROP: if (acc && s_axis.tlast) state_q <= WR_IDLE;
        default: state_q <= WR_IDLE;
      endcase
    end
  end

  assign pop      = m_axis.tvalid && m_axis.tready;
  assign last_out = sk0_q[BW-1];

  always_ff @(posedge aclk) begin
    if (areset) begin
      pkt_cnt_q <= '0;
    end else if (commit && !(pop && last_out)) begin
      if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end else if (!commit && pop && last_out) begin
      if (pkt_cnt_q != '0) pkt_cnt_q <= pkt_cnt_q - 1'b1;
    end
  end
  assign pkt_cnt = pkt_cnt_q;

  // ra_p feeds the RAM, rd_p retires on output handshake so skid-held beats
  // still occupy RAM space; cm_vis_q delays commit visibility by one cycle.
  assign occ   = {1'b0, sk_cnt_q} + {2'b0, rd_vld_q};
  assign issue = (ra_p_q != cm_vis_q) && ((occ < 3'd2) || pop);

  always_ff @(posedge aclk) begin
    if (areset) begin
      cm_vis_q <= '0;
      ra_p_q   <= '0;
      rd_p_q   <= '0;
      rd_vld_q <= 1'b0;
      sk_cnt_q <= '0;
      sk0_q    <= '0;
      sk1_q    <= '0;
    end else begin
      cm_vis_q <= cm_p_q;
      rd_vld_q <= issue;
      if (issue) ra_p_q <= ra_p_q + 1'b1;
      if (pop)   rd_p_q <= rd_p_q + 1'b1;
      case ({rd_vld_q, pop})
        2'b10: begin
          if (sk_cnt_q == 2'd0) sk0_q <= ram_rdata;
          else                  sk1_q <= ram_rdata;
          sk_cnt_q <= sk_cnt_q + 2'd1;
        end
        2'b01: begin
          sk0_q    <= sk1_q;
          sk_cnt_q <= sk_cnt_q - 2'd1;
        end
        2'b11: begin
          if (sk_cnt_q == 2'd1) begin
            sk0_q <= ram_rdata;
          end else begin
            sk0_q <= sk1_q;
            sk1_q <= ram_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axis.tvalid    = (sk_cnt_q != 2'd0);
  assign m_axis.tdata     = sk0_q[DW-1:0];
  assign m_axis.tuser_mty = sk0_q[DW +: MW];
  assign m_axis.tlast     = sk0_q[BW-1];

`ifdef PKT_FIFO_DROP_STATS_EN
  logic [31:0] drop_cnt_q;
  always_ff @(posedge aclk) begin
    if (areset)                               drop_cnt_q <= '0;
    else if (drop_ev && (drop_cnt_q != '1))   drop_cnt_q <= drop_cnt_q + 32'd1;
  end
  assign drop_cnt = drop_cnt_q;
`endif

endmodule
